// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared state type, defaults and round-robin pick helper for axis_wrr_arbiter
package axis_arb_pkg;

  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_WEIGHT_W = 4;
  localparam int MAX_SRC      = 8;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= MAX_SRC).
  function automatic logic [2:0] rr_pick(input logic [MAX_SRC-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      idx = (i + 32'(ptr)) % n;
      if (i < n && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry skid buffer with registered outputs; entry 0 drives the output
module axis_skid_buf #(
  parameter int DATA_W = 32,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [USER_W-1:0] out_user,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] data0, data1;
  logic [USER_W-1:0] user0, user1;
  logic [1:0]        count;
  logic              push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = data0;
  assign out_user  = user0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0 <= '0;
      data1 <= '0;
      user0 <= '0;
      user1 <= '0;
      count <= 2'd0;
    end else if (pop && !push) begin
      data0 <= data1;
      user0 <= user1;
      count <= count - 2'd1;
    end else if (push && !pop) begin
      if (count == 2'd0) begin
        data0 <= in_data;
        user0 <= in_user;
      end else begin
        data1 <= in_data;
        user1 <= in_user;
      end
      count <= count + 2'd1;
    end else if (push && pop) begin
      // Only reachable with one entry held: the new beat replaces the departing head.
      data0 <= in_data;
      user0 <= in_user;
    end
  end

endmodule

// File: rtl/axis_wrr_arbiter.sv
// rtl/axis_wrr_arbiter.sv - packet-atomic weighted round-robin AXI-Stream merger
// Optional ARB_TID_EN adds m_axis_tid carrying the source index of each beat.
module axis_wrr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int  NUM_SRC  = 4,
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  WEIGHT_W = DEF_WEIGHT_W,
  localparam int SRC_W    = $clog2(NUM_SRC)
) (
  input  logic                     axis_aclk,
  input  logic                     axis_aresetn,
`ifdef ARB_TID_EN
  output logic [SRC_W-1:0]         m_axis_tid,
`endif
  input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]          s_axis_tvalid,
  input  logic [NUM_SRC-1:0]          s_axis_tlast,
  output logic [NUM_SRC-1:0]          s_axis_tready,
  input  logic [NUM_SRC*WEIGHT_W-1:0] cfg_weight,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     gnt_valid,
  output logic [SRC_W-1:0]         gnt_idx
);

`ifdef ARB_TID_EN
  localparam int USER_W = 1 + SRC_W;
`else
  localparam int USER_W = 1;
`endif

  arb_state_t          state, state_next;
  logic [SRC_W-1:0]    gnt, ptr, sel, ptr_after;
  logic [WEIGHT_W-1:0] wt, pkt_cnt, cfg_sel;
  logic                mid_pkt, accept, last_pkt, skid_ready;
  logic                src_valid, src_last;
  logic [DATA_W-1:0]   src_data;
  logic [MAX_SRC-1:0]  valid_pad;
  logic [USER_W-1:0]   skid_user_in, skid_user_out;

  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_SRC-1:0]   = s_axis_tvalid;
  end

  assign sel       = SRC_W'(rr_pick(valid_pad, 3'(ptr), NUM_SRC));
  assign cfg_sel   = cfg_weight[int'(sel)*WEIGHT_W +: WEIGHT_W];
  assign src_valid = s_axis_tvalid[gnt];
  assign src_last  = s_axis_tlast[gnt];
  assign src_data  = s_axis_tdata[int'(gnt)*DATA_W +: DATA_W];
  assign last_pkt  = ((pkt_cnt + WEIGHT_W'(1)) == wt);
  assign ptr_after = (gnt == SRC_W'(NUM_SRC - 1)) ? '0 : gnt + SRC_W'(1);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state <= ST_IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (|s_axis_tvalid) state_next = ST_GRANT;
      ST_GRANT: begin
        if (accept && src_last && last_pkt)  state_next = ST_IDLE;
        else if (!mid_pkt && !src_valid)     state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    accept        = 1'b0;
    if (state == ST_GRANT) begin
      s_axis_tready[gnt] = skid_ready;
      accept             = src_valid && skid_ready;
    end
    gnt_valid = (state == ST_GRANT);
    gnt_idx   = gnt;
  end

  // Weight is latched at grant time so mid-grant config changes wait for the next grant.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      gnt     <= '0;
      ptr     <= '0;
      wt      <= '0;
      pkt_cnt <= '0;
      mid_pkt <= 1'b0;
    end else begin
      if (state == ST_IDLE && |s_axis_tvalid) begin
        gnt     <= sel;
        pkt_cnt <= '0;
        mid_pkt <= 1'b0;
        wt      <= (cfg_sel == '0) ? WEIGHT_W'(1) : cfg_sel;
      end
      if (accept) begin
        mid_pkt <= !src_last;
        if (src_last && !last_pkt) pkt_cnt <= pkt_cnt + WEIGHT_W'(1);
      end
      if (state == ST_GRANT && state_next == ST_IDLE) ptr <= ptr_after;
    end
  end

`ifdef ARB_TID_EN
  assign skid_user_in = {gnt, src_last};
  assign m_axis_tid   = skid_user_out[USER_W-1:1];
`else
  assign skid_user_in = src_last;
`endif
  assign m_axis_tlast = skid_user_out[0];

  axis_skid_buf #(
    .DATA_W (DATA_W),
    .USER_W (USER_W)
  ) u_skid (
    .clk       (axis_aclk),
    .rst_n     (axis_aresetn),
    .in_data   (src_data),
    .in_user   (skid_user_in),
    .in_valid  (accept),
    .in_ready  (skid_ready),
    .out_data  (m_axis_tdata),
    .out_user  (skid_user_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// tb/tb_axis_wrr_arbiter.sv - self-checking bench for axis_wrr_arbiter
module tb_axis_wrr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int SW = 2;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [N*WW-1:0] cfg;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tlast, m_tready, gnt_valid;
  logic [SW-1:0]   gnt_idx;
`ifdef ARB_TID_EN
  logic [SW-1:0]   m_tid;
`endif

  axis_wrr_arbiter #(.NUM_SRC(N), .DATA_W(DW), .WEIGHT_W(WW)) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
`ifdef ARB_TID_EN
    .m_axis_tid    (m_tid),
`endif
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .cfg_weight    (cfg),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .gnt_valid     (gnt_valid),
    .gnt_idx       (gnt_idx)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int unsigned sq[N][$];
  bit          lq[N][$];
  int unsigned md[N][$];
  bit          ml[N][$];
  int unsigned exp_d[$];
  bit          exp_l[$];
  int unsigned out_d[$];
  bit          out_l[$];
  int          out_c[$];
  int          wts[N];
  bit          mid[N];
  int          acc_cnt[N];
  int          last_acc_cyc[N];
  int          first_gnt_cyc[N];
  bit          gap_en, bp_mode, prev_stall, prev_l;
  logic [DW-1:0] prev_d;
  logic [15:0] lfsr = 16'hACE1;
  int unsigned serial = 0;
  int          t_start;

  typedef struct {
    bit         pre_en;
    int         pre_src;
    logic [N-1:0] mask;
    logic       exp_gv;
    int         exp_idx;
    logic [N-1:0] exp_rdy;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      sq[i].delete(); lq[i].delete(); md[i].delete(); ml[i].delete();
      mid[i] = 1'b0; acc_cnt[i] = 0; last_acc_cyc[i] = -1; first_gnt_cyc[i] = -1;
    end
    out_d.delete(); out_l.delete(); out_c.delete();
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b1;
    clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_cfg();
    for (int i = 0; i < N; i++) cfg[i*WW +: WW] = WW'(wts[i]);
  endtask

  task automatic add_beat(input int s, input int unsigned d, input bit l);
    sq[s].push_back(d); lq[s].push_back(l);
    md[s].push_back(d); ml[s].push_back(l);
  endtask

  task automatic add_pkt(input int s, input int len);
    for (int b = 0; b < len; b++) begin
      add_beat(s, (32'(s) << 24) | serial, b == len - 1);
      serial++;
    end
  endtask

  // Reference: whole packets taken in rotation from ptr, up to max(weight,1) per grant.
  task automatic run_model();
    int ptr = 0;
    int g, w;
    bit l;
    exp_d.delete(); exp_l.delete();
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && md[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
      if (g < 0) break;
      w = (wts[g] == 0) ? 1 : wts[g];
      for (int p = 0; p < w && md[g].size() > 0; p++) begin
        do begin
          l = ml[g].pop_front();
          exp_d.push_back(md[g].pop_front());
          exp_l.push_back(l);
        end while (!l);
      end
      ptr = (g + 1) % N;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() > 0) begin
        s_tvalid[i] = !(gap_en && mid[i] && $urandom_range(3) == 0);
        s_tdata[i*DW +: DW] = sq[i][0];
        s_tlast[i] = lq[i][0];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i] = 1'b0;
      end
    end
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    m_tready = bp_mode ? lfsr[0] : 1'b1;
  endtask

  task automatic cycle();
    bit acc[N];
    @(negedge clk);
    if (prev_stall) begin
      chk("stable_valid", m_tvalid, 1'b1);
      chk("stable_data", m_tdata, prev_d);
      chk("stable_last", m_tlast, prev_l);
    end
    prev_stall = m_tvalid && !m_tready;
    prev_d = m_tdata;
    prev_l = m_tlast;
    if (m_tvalid && m_tready) begin
      out_d.push_back(m_tdata); out_l.push_back(m_tlast); out_c.push_back(cyc);
    end
    if (gnt_valid && first_gnt_cyc[gnt_idx] < 0) first_gnt_cyc[gnt_idx] = cyc;
    for (int i = 0; i < N; i++) begin
      acc[i] = s_tvalid[i] && s_tready[i];
      if (acc[i]) begin
        acc_cnt[i]++;
        if (s_tlast[i]) last_acc_cyc[i] = cyc;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        mid[i] = !lq[i][0];
        void'(sq[i].pop_front());
        void'(lq[i].pop_front());
      end
    drive();
  endtask

  task automatic run_check(input string tag, input int budget);
    int b = 0;
    run_model();
    drive();
    t_start = cyc;
    while (out_d.size() < exp_d.size() && b < budget) begin
      cycle();
      b++;
    end
    repeat (4) cycle();
    chk({tag, "_beat_count"}, out_d.size(), exp_d.size());
    for (int j = 0; j < exp_d.size() && j < out_d.size(); j++) begin
      chk($sformatf("%s_data%0d", tag, j), out_d[j], exp_d[j]);
      chk($sformatf("%s_last%0d", tag, j), out_l[j], exp_l[j]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b;
    vecs[0] = '{1'b0, 0, 4'b0000, 1'b0, 0, 4'b0000};
    vecs[1] = '{1'b0, 0, 4'b0001, 1'b1, 0, 4'b0001};
    vecs[2] = '{1'b0, 0, 4'b1010, 1'b1, 1, 4'b0010};
    vecs[3] = '{1'b0, 0, 4'b1000, 1'b1, 3, 4'b1000};
    vecs[4] = '{1'b1, 0, 4'b0001, 1'b1, 0, 4'b0001};
    vecs[5] = '{1'b1, 1, 4'b1011, 1'b1, 3, 4'b1000};
    vecs[6] = '{1'b1, 3, 4'b1100, 1'b1, 2, 4'b0100};
    vecs[7] = '{1'b1, 2, 4'b0110, 1'b1, 1, 4'b0010};
    vecs[8] = '{1'b1, 3, 4'b1001, 1'b1, 0, 4'b0001};

    s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0; cfg = '0;
    gap_en = 1'b0; bp_mode = 1'b0;
    clear();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_gnt_valid", gnt_valid, 0);
    chk("rst_gnt_idx", gnt_idx, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Grant selection from ptr; a weight-0 single-beat packet first moves ptr to pre_src+1.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      cfg = '0;
      if (vecs[v].pre_en) begin
        s_tvalid[vecs[v].pre_src] = 1'b1;
        s_tlast[vecs[v].pre_src]  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_tlast = '0;
      end
      s_tvalid = vecs[v].mask;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_gnt_valid", v), gnt_valid, vecs[v].exp_gv);
      if (vecs[v].exp_gv) chk($sformatf("vec%0d_gnt_idx", v), gnt_idx, vecs[v].exp_idx);
      chk($sformatf("vec%0d_s_tready", v), s_tready, vecs[v].exp_rdy);
    end

    // Single source: beats 1..10, output starts two cycles after tvalid, one beat per cycle.
    do_reset();
    wts = '{1, 1, 1, 1}; set_cfg();
    for (int k = 1; k <= 10; k++) add_beat(0, k, k == 10);
    run_check("single", 100);
    for (int j = 0; j < out_c.size() && j < 10; j++)
      chk($sformatf("single_cycle%0d", j), out_c[j], t_start + 2 + j);

    // Equal weights alternate packets.
    do_reset();
    wts = '{1, 1, 1, 1}; set_cfg();
    for (int p = 0; p < 3; p++) begin add_pkt(0, 4); add_pkt(1, 4); end
    run_check("fair", 300);

    // Weight 3 vs weight 0 (treated as 1).
    do_reset();
    wts = '{3, 0, 1, 1}; set_cfg();
    for (int p = 0; p < 6; p++) add_pkt(0, 2);
    for (int p = 0; p < 2; p++) add_pkt(1, 2);
    run_check("weight", 300);

    // Pseudorandom sink back-pressure.
    do_reset();
    bp_mode = 1'b1;
    add_pkt(0, 10); add_pkt(3, 10);
    run_check("bp", 400);
    bp_mode = 1'b0;

    // Grantee with weight left but no data releases to the next valid source.
    do_reset();
    wts = '{1, 1, 4, 1}; set_cfg();
    add_pkt(2, 3); add_pkt(3, 2);
    run_check("idle", 100);
    chk("idle_gnt_move_cycle", first_gnt_cyc[3], last_acc_cyc[2] + 3);

    // Reset mid-packet after moving ptr to 3; afterwards ptr must restart at 0.
    do_reset();
    wts = '{1, 1, 1, 1}; set_cfg();
    add_pkt(2, 2);
    run_check("pre_rst", 100);
    add_pkt(0, 10);
    drive();
    b = 0;
    while (acc_cnt[0] < 5 && b < 200) begin cycle(); b++; end
    chk("rst_reach_beat5", acc_cnt[0], 5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m_tvalid", m_tvalid, 0);
    chk("rst_mid_gnt_valid", gnt_valid, 0);
    chk("rst_mid_s_tready", s_tready, 0);
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    add_pkt(1, 4); add_pkt(3, 3);
    run_check("after_rst", 200);

    // Randomized traffic with mid-packet gaps and random weights.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      gap_en  = 1'b1;
      bp_mode = $urandom_range(1);
      for (int i = 0; i < N; i++) wts[i] = $urandom_range(3);
      set_cfg();
      for (int i = 0; i < N; i++) begin
        int np = $urandom_range(3);
        for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 5));
      end
      run_check($sformatf("rand%0d", r), 2000);
    end
    gap_en = 1'b0; bp_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
